// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: requester indices and FSM states.
package arb_pkg;

  localparam int NUM_REQ   = 3;
  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_LOAD  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Index of a one-hot owner vector; an empty vector maps to the fetch port
  function automatic logic [1:0] owner_idx(input logic [NUM_REQ-1:0] oh);
    case (oh)
      3'b010:  owner_idx = 2'd1;
      3'b100:  owner_idx = 2'd2;
      default: owner_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the memory port arbiter: per-port request, address, data and handshake.
interface mem_port_arbiter_if
  import arb_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] we;
  logic [AW-1:0]      addr0;
  logic [AW-1:0]      addr1;
  logic [AW-1:0]      addr2;
  logic [DW-1:0]      wdata0;
  logic [DW-1:0]      wdata1;
  logic [DW-1:0]      wdata2;
  logic               lock1;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] ack;
  logic [DW-1:0]      rdata;

  modport master (
    output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, lock1,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, lock1,
    output gnt, ack, rdata
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection; ARB_ROUND_ROBIN_EN selects rotating priority, otherwise R2 > R1 > R0.
module arb_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [1:0]         last,
`endif
  output logic [NUM_REQ-1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] p0_s;
  logic [1:0] p1_s;
  logic [1:0] p2_s;

  // Search order begins one past the previous owner
  always_comb begin
    case (last)
      2'd0:    begin p0_s = 2'd1; p1_s = 2'd2; p2_s = 2'd0; end
      2'd1:    begin p0_s = 2'd2; p1_s = 2'd0; p2_s = 2'd1; end
      default: begin p0_s = 2'd0; p1_s = 2'd1; p2_s = 2'd2; end
    endcase
  end

  // First requester found in search order wins
  always_comb begin
    gnt = 3'b000;
    if (req[p0_s]) begin
      gnt[p0_s] = 1'b1;
    end else if (req[p1_s]) begin
      gnt[p1_s] = 1'b1;
    end else if (req[p2_s]) begin
      gnt[p2_s] = 1'b1;
    end else begin
      gnt = 3'b000;
    end
  end
`else
  // Loader beats data beats fetch
  always_comb begin
    gnt = 3'b000;
    if (req[REQ_LOAD]) begin
      gnt = 3'b100;
    end else if (req[REQ_DATA]) begin
      gnt = 3'b010;
    end else if (req[REQ_FETCH]) begin
      gnt = 3'b001;
    end else begin
      gnt = 3'b000;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch/data/loader with locked R1 bursts.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed priority.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MEM_LAT  = 1,
  parameter int LOCK_MAX = 8
)(
  input  logic                clk,
  input  logic                proc_rst,
  mem_port_arbiter_if.slave   bus,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic                mem_rd,
  output logic                mem_wr,
  input  logic [DW-1:0]       mem_rdata,
  output logic                busy
);

  localparam int BW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam int WW = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam logic [BW-1:0] LOCK_LAST = BW'(LOCK_MAX - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  state_e             state_r, state_s;
  logic [NUM_REQ-1:0] win_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_s, ack_r, ack_s;
  logic [DW-1:0]      rdata_r, rdata_s, wdata_r, wdata_s, sel_wdata_s;
  logic [AW-1:0]      addr_r, addr_s, sel_addr_s;
  logic               we_r, we_s, sel_we_s;
  logic               rd_r, rd_s, wr_r, wr_s, busy_r, busy_s;
  logic [BW-1:0]      bcnt_r, bcnt_s;
  logic [WW-1:0]      wcnt_r, wcnt_s;
  logic               cont_s;
`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0]         last_r, last_s;
`endif

  arb_pick u_pick (
    .req  (bus.req),
`ifdef ARB_ROUND_ROBIN_EN
    .last (last_r),
`endif
    .gnt  (win_s)
  );

  // Fetch the IDLE winner's access parameters
  always_comb begin
    case (win_s)
      3'b100:  begin sel_we_s = bus.we[REQ_LOAD]; sel_addr_s = bus.addr2; sel_wdata_s = bus.wdata2; end
      3'b010:  begin sel_we_s = bus.we[REQ_DATA]; sel_addr_s = bus.addr1; sel_wdata_s = bus.wdata1; end
      default: begin sel_we_s = bus.we[REQ_FETCH]; sel_addr_s = bus.addr0; sel_wdata_s = bus.wdata0; end
    endcase
  end

  assign cont_s = (state_r == RESP) && gnt_r[REQ_DATA] && bus.lock1 &&
                  bus.req[REQ_DATA] && (bcnt_r < LOCK_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req != 3'b000) state_s = ACCESS;
        else                   state_s = IDLE;
      end
      ACCESS: begin
        if (MEM_LAT > 1) state_s = WAIT;
        else             state_s = RESP;
      end
      WAIT: begin
        if (wcnt_r == WAIT_LAST) state_s = RESP;
        else                     state_s = WAIT;
      end
      RESP: begin
        if (cont_s) state_s = ACCESS;
        else        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of every registered output; strobes fire on entry to ACCESS
  always_comb begin
    gnt_s   = gnt_r;
    ack_s   = 3'b000;
    rdata_s = rdata_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    we_s    = we_r;
    rd_s    = 1'b0;
    wr_s    = 1'b0;
    bcnt_s  = bcnt_r;
    wcnt_s  = wcnt_r;
`ifdef ARB_ROUND_ROBIN_EN
    last_s  = last_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.req != 3'b000) begin
          gnt_s   = win_s;
          addr_s  = sel_addr_s;
          wdata_s = sel_wdata_s;
          we_s    = sel_we_s;
          rd_s    = ~sel_we_s;
          wr_s    = sel_we_s;
        end else begin
          gnt_s = 3'b000;
        end
      end
      ACCESS: wcnt_s = {WW{1'b0}};
      WAIT: begin
        if (wcnt_r == WAIT_LAST) wcnt_s = {WW{1'b0}};
        else                     wcnt_s = wcnt_r + 1'b1;
      end
      RESP: begin
        ack_s = gnt_r;
        if (!we_r) rdata_s = mem_rdata;
        else       rdata_s = rdata_r;
        if (cont_s) begin
          bcnt_s  = bcnt_r + 1'b1;
          addr_s  = bus.addr1;
          wdata_s = bus.wdata1;
          we_s    = bus.we[REQ_DATA];
          rd_s    = ~bus.we[REQ_DATA];
          wr_s    = bus.we[REQ_DATA];
        end else begin
          gnt_s  = 3'b000;
          bcnt_s = {BW{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
          last_s = owner_idx(gnt_r);
`endif
        end
      end
      default: gnt_s = 3'b000;
    endcase
    busy_s = (state_s != IDLE);
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      gnt_r   <= 3'b000;
      ack_r   <= 3'b000;
      rdata_r <= {DW{1'b0}};
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
      we_r    <= 1'b0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      busy_r  <= 1'b0;
      bcnt_r  <= {BW{1'b0}};
      wcnt_r  <= {WW{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
      last_r  <= 2'd0;
`endif
    end else begin
      gnt_r   <= gnt_s;
      ack_r   <= ack_s;
      rdata_r <= rdata_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      we_r    <= we_s;
      rd_r    <= rd_s;
      wr_r    <= wr_s;
      busy_r  <= busy_s;
      bcnt_r  <= bcnt_s;
      wcnt_r  <= wcnt_s;
`ifdef ARB_ROUND_ROBIN_EN
      last_r  <= last_s;
`endif
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.ack   = ack_r;
  assign bus.rdata = rdata_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_rd    = rd_r;
  assign mem_wr    = wr_r;
  assign busy      = busy_r;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between three requesters: instruction fetch (R0), data load/store including LM/SM bursts (R1), and the boot/test program loader (R2).
- Sits between the multicycle controller/datapath and the memory model, replacing direct memread/memwrite strobes.
- Serialises accesses and supports locked bursts of up to 8 beats for LM/SM.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MEM_LAT, 1, memory read latency in cycles (>=1); mem_rdata is valid MEM_LAT cycles after mem_rd.
- LOCK_MAX, 8, maximum beats one locked owner may hold the port.

Ports:
- clk  in  1  clock; all logic on rising edge.
- proc_rst  in  1  reset, synchronous, active-high.
- req[2:0]  in  3  per-requester access request.
- we[2:0]  in  3  per-requester write enable (1 = write).
- addr0/addr1/addr2  in  AW each  per-requester address.
- wdata0/wdata1/wdata2  in  DW each  per-requester write data.
- lock1  in  1  R1 burst lock (LM/SM).
- gnt[2:0]  out  3  one-hot owner indication.
- ack[2:0]  out  3  one-cycle completion pulse per requester.
- rdata  out  DW  read data, valid in the ack cycle.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, ack=0, rdata=0, mem_addr=0, mem_wdata=0, mem_rd=0, mem_wr=0, busy=0, state=IDLE, beat count=0, wait count=0.
- IDLE:
  - If any req bit is set, select a winner (fixed priority R2 > R1 > R0).
  - Latch the winner's addr, we and wdata; set gnt one-hot; go to ACCESS.
  - No req: stay in IDLE.
- ACCESS: drive mem_addr/mem_wdata from the latch. Assert mem_rd (we=0) or mem_wr (we=1) for exactly one cycle. Go to WAIT if MEM_LAT>1, else RESP.
- WAIT: count MEM_LAT-1 cycles with strobes low, then go to RESP.
- RESP:
  - Capture mem_rdata into rdata; pulse ack[owner] for one cycle.
  - Writes use the same latency; rdata is unchanged on writes.
- Latency: req sampled in IDLE at cycle t gives ack at cycle t+MEM_LAT+1.
- Leaving RESP:
  - If owner=R1, lock1=1, req[1]=1 and beat count < LOCK_MAX-1, increment the beat count and go straight to ACCESS. The new addr/we/wdata are latched in RESP and gnt is held.
  - Otherwise clear gnt and the beat count and go to IDLE.
- Consequences of the exit rule:
  - A locked burst of N beats completes in N*(MEM_LAT+1) cycles after the first ACCESS.
  - At LOCK_MAX beats the burst is released even if lock1 stays high; R1 must re-arbitrate.
- Requester obligations:
  - Hold req until ack.
  - Deasserting req mid-transaction does not abort; the ack still pulses.
  - A requester may reassert req in its ack cycle. It is eligible at the next IDLE sample, i.e. the cycle after ack.
- Simultaneous requests: only the winner is granted; losers stay pending. lock1 is ignored unless R1 is the current owner.
- Reset mid-operation: on the next edge with proc_rst=1, all outputs return to reset values. An in-flight write strobe already issued is not retracted; no ack is produced.
- Invariants:
  - gnt is never more than one-hot.
  - mem_rd and mem_wr are never both high.
  - Write data reaching memory is never corrupted by a requester changing wdata after grant.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: IDLE arbitration is round-robin. A rotating pointer gives priority starting from the requester after the last owner. The pointer resets to R0 so that R1 is favoured first, and updates when the owner releases. Locking is unchanged.
- Undefined: fixed priority R2 > R1 > R0.

Decomposition:
- Package arb_pkg holds:
  - requester index constants REQ_FETCH=0, REQ_DATA=1, REQ_LOAD=2;
  - state enum {IDLE, ACCESS, WAIT, RESP};
  - NUM_REQ=3.
- Sub-module arb_pick: purely combinational winner selection (req vector, last owner) -> one-hot grant, containing both the fixed-priority and round-robin variants.

Test Plan:
- Single R0 read of addr 0x0004 with memory 0x3A5C, MEM_LAT=1 -> mem_rd high one cycle, ack[0] two cycles after req, rdata=0x3A5C, gnt returns to 0.
- req=3'b111 in the same cycle -> fixed mode grants R2, then R1, then R0. Round-robin build from reset grants R1, R2, R0.
- R1 locked SM burst, 8 writes to 0x0100..0x0107 with R0 requesting throughout -> 8 consecutive mem_wr beats with gnt[1] held, then R0 granted. A 9th locked beat must re-arbitrate.
- MEM_LAT=3 read -> ack exactly 4 cycles after the IDLE sample; mem_rd high exactly one cycle.
- proc_rst asserted during WAIT -> next cycle all outputs 0, state IDLE, no ack. The first request after release is served normally.
- R1 write of 0xBEEF to 0x0020 with wdata1 changed to 0x0000 after grant -> memory holds 0xBEEF and ack[1] pulses.
